iir_coeff_loader: RTL and testbench

IIR_COEFF_LOADER -- requirements
Module: iir_coeff_loader

---
 rtl/iir_coeff_loader_pkg.sv | 24 ++
 rtl/iir_coeff_bank.sv | 38 +++
 rtl/iir_coeff_loader.sv | 165 ++++++++++++++++
 tb/tb_iir_coeff_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_coeff_loader_pkg.sv
// Shared definitions for the IIR coefficient loader: FSM states, notch-filter
// select encoding, bank depth and the word-legality helper.
package iir_coeff_loader_pkg;

  localparam int COEFF_DEPTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_1MHZ    = 2'd0,
    SEL_2MHZ    = 2'd1,
    SEL_2_4MHZ  = 2'd2,
    SEL_ILLEGAL = 2'd3
  } notch_sel_e;

  function automatic logic cfg_word_legal(input logic [1:0] sel, input logic [2:0] idx);
    return (sel != SEL_ILLEGAL) && (idx < 3'(COEFF_DEPTH));
  endfunction

endpackage

// File: rtl/iir_coeff_bank.sv
// One shadow coefficient bank for a single notch filter, plus the compare of
// the filter's readback against the shadow contents.
module iir_coeff_bank
  import iir_coeff_loader_pkg::*;
#(
  parameter int COEFF_WIDTH = 20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en_i,
  input  logic [2:0]                         wr_idx_i,
  input  logic [COEFF_WIDTH-1:0]             wr_data_i,
  input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] readback_i,
  output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] shadow_o,
  output logic                               mismatch_o
);

  logic [COEFF_WIDTH-1:0] shadow_q [COEFF_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COEFF_DEPTH; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < COEFF_DEPTH; i++) begin
        if (wr_en_i && (wr_idx_i == 3'(i))) shadow_q[i] <= wr_data_i;
      end
    end
  end

  // Slot i occupies bits [i*COEFF_WIDTH +: COEFF_WIDTH] of the flat bus.
  always_comb begin
    shadow_o = '0;
    for (int i = 0; i < COEFF_DEPTH; i++) shadow_o[i*COEFF_WIDTH +: COEFF_WIDTH] = shadow_q[i];
  end

  assign mismatch_o = (shadow_o != readback_i);

endmodule

// File: rtl/iir_coeff_loader.sv
// Loads coefficient bursts into three notch-filter shadow banks and commits a
// bank with a one-cycle write strobe. Define IIR_LOADER_READBACK_EN to add the
// CHECK state that verifies the filter readback after each commit.
module iir_coeff_loader
  import iir_coeff_loader_pkg::*;
#(
  parameter int COEFF_WIDTH = 20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [1:0]                         cfg_sel,
  input  logic [2:0]                         cfg_idx,
  input  logic [COEFF_WIDTH-1:0]             cfg_data,
  input  logic                               cfg_last,
  output logic                               coeff_wr_en_1MHz,
  output logic                               coeff_wr_en_2MHz,
  output logic                               coeff_wr_en_2_4MHz,
  output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_in_1MHz,
  output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_in_2MHz,
  output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_in_2_4MHz,
  input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_out_1MHz,
  input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_out_2MHz,
  input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_out_2_4MHz,
  input  logic                               overflow_1MHz,
  input  logic                               overflow_2MHz,
  input  logic                               overflow_2_4MHz,
  input  logic                               underflow_1MHz,
  input  logic                               underflow_2MHz,
  input  logic                               underflow_2_4MHz,
  input  logic                               status_clr,
  output logic [2:0]                         sticky_ovf,
  output logic [2:0]                         sticky_udf,
  output logic                               load_done,
  output logic                               verify_err,
  output logic                               cfg_err,
  output logic                               busy,
  output logic [1:0]                         state_dbg
);

  // cfg handshake: a word transfers on a rising edge where cfg_valid and
  // cfg_ready are both 1; cfg_ready is 1 exactly when the FSM is in IDLE.
  state_e     state_q, state_d;
  logic [1:0] target_q, target_d;
  logic       xfer, word_legal, word_ok;
  logic [2:0] bank_wr, wr_en_vec, mismatch;
  logic       verify_set;
  logic [2:0] sticky_ovf_q, sticky_ovf_d, sticky_udf_q, sticky_udf_d;
  logic       cfg_err_q, cfg_err_d;

  assign cfg_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;
  assign xfer       = cfg_valid && cfg_ready;
  assign word_legal = cfg_word_legal(cfg_sel, cfg_idx);
  assign word_ok    = xfer && word_legal;
  assign bank_wr    = word_ok ? (3'b001 << cfg_sel) : 3'b000;

  iir_coeff_bank #(.COEFF_WIDTH(COEFF_WIDTH)) u_bank_1mhz (
    .clk(clk), .rst(rst), .wr_en_i(bank_wr[0]), .wr_idx_i(cfg_idx), .wr_data_i(cfg_data),
    .readback_i(coeff_out_1MHz), .shadow_o(coeff_in_1MHz), .mismatch_o(mismatch[0])
  );

  iir_coeff_bank #(.COEFF_WIDTH(COEFF_WIDTH)) u_bank_2mhz (
    .clk(clk), .rst(rst), .wr_en_i(bank_wr[1]), .wr_idx_i(cfg_idx), .wr_data_i(cfg_data),
    .readback_i(coeff_out_2MHz), .shadow_o(coeff_in_2MHz), .mismatch_o(mismatch[1])
  );

  iir_coeff_bank #(.COEFF_WIDTH(COEFF_WIDTH)) u_bank_2_4mhz (
    .clk(clk), .rst(rst), .wr_en_i(bank_wr[2]), .wr_idx_i(cfg_idx), .wr_data_i(cfg_data),
    .readback_i(coeff_out_2_4MHz), .shadow_o(coeff_in_2_4MHz), .mismatch_o(mismatch[2])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // load_done marks the last busy cycle, so IDLE accepts a word right after it.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    wr_en_vec  = 3'b000;
    load_done  = 1'b0;
    verify_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (word_ok && cfg_last) begin
          state_d  = ST_WRITE;
          target_d = cfg_sel;
        end
      end
      ST_WRITE: begin
        wr_en_vec = 3'b001 << target_q;
`ifdef IIR_LOADER_READBACK_EN
        state_d   = ST_CHECK;
`else
        state_d   = ST_IDLE;
        load_done = 1'b1;
`endif
      end
`ifdef IIR_LOADER_READBACK_EN
      ST_CHECK: begin
        verify_set = mismatch[target_q];
        load_done  = 1'b1;
        state_d    = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign coeff_wr_en_1MHz   = wr_en_vec[0];
  assign coeff_wr_en_2MHz   = wr_en_vec[1];
  assign coeff_wr_en_2_4MHz = wr_en_vec[2];

  // A set event in the same cycle as status_clr wins over the clear.
  always_comb begin
    sticky_ovf_d = (status_clr ? 3'b000 : sticky_ovf_q) |
                   {overflow_2_4MHz, overflow_2MHz, overflow_1MHz};
    sticky_udf_d = (status_clr ? 3'b000 : sticky_udf_q) |
                   {underflow_2_4MHz, underflow_2MHz, underflow_1MHz};
    cfg_err_d    = (status_clr ? 1'b0 : cfg_err_q) | (xfer && !word_legal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf_q <= 3'b000;
      sticky_udf_q <= 3'b000;
      cfg_err_q    <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_udf_q <= sticky_udf_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
  assign sticky_udf = sticky_udf_q;
  assign cfg_err    = cfg_err_q;

`ifdef IIR_LOADER_READBACK_EN
  logic verify_err_q, verify_err_d;

  assign verify_err_d = (status_clr ? 1'b0 : verify_err_q) | verify_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) verify_err_q <= 1'b0;
    else     verify_err_q <= verify_err_d;
  end

  assign verify_err = verify_err_q;
`else
  logic unused_readback;
  assign unused_readback = ^{mismatch, verify_set};
  assign verify_err      = 1'b0;
`endif

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader: the driver pushes expected commits into
// a queue and a negedge monitor pops and compares on every write strobe.
module tb_iir_coeff_loader;
  import iir_coeff_loader_pkg::*;

  localparam int W  = 20;
  localparam int BW = W * COEFF_DEPTH;
`ifdef IIR_LOADER_READBACK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk, rst;
  logic          cfg_valid, cfg_ready, cfg_last;
  logic [1:0]    cfg_sel;
  logic [2:0]    cfg_idx;
  logic [W-1:0]  cfg_data;
  logic          wr1, wr2, wr24;
  logic [BW-1:0] cin1, cin2, cin24, cout1, cout2, cout24;
  logic          ovf1, ovf2, ovf24, udf1, udf2, udf24, status_clr;
  logic [2:0]    sticky_ovf, sticky_udf;
  logic          load_done, verify_err, cfg_err, busy;
  logic [1:0]    state_dbg;

  int            checks = 0;
  int            errors = 0;
  int            commits_exp = 0;
  int            ld_seen = 0;
  logic          prev_wr = 1'b0;
  logic [BW+1:0] exp_q[$];
  logic [W-1:0]  model [3][COEFF_DEPTH];
  logic [BW-1:0] co_mask [3];
  logic [BW-1:0] co_flat [3];

  iir_coeff_loader #(.COEFF_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .coeff_wr_en_1MHz(wr1), .coeff_wr_en_2MHz(wr2), .coeff_wr_en_2_4MHz(wr24),
    .coeff_in_1MHz(cin1), .coeff_in_2MHz(cin2), .coeff_in_2_4MHz(cin24),
    .coeff_out_1MHz(cout1), .coeff_out_2MHz(cout2), .coeff_out_2_4MHz(cout24),
    .overflow_1MHz(ovf1), .overflow_2MHz(ovf2), .overflow_2_4MHz(ovf24),
    .underflow_1MHz(udf1), .underflow_2MHz(udf2), .underflow_2_4MHz(udf24),
    .status_clr(status_clr), .sticky_ovf(sticky_ovf), .sticky_udf(sticky_udf),
    .load_done(load_done), .verify_err(verify_err), .cfg_err(cfg_err), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Filter model: readback equals the bench's shadow model, optionally corrupted.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      co_flat[s] = '0;
      for (int i = 0; i < COEFF_DEPTH; i++) co_flat[s][i*W +: W] = model[s][i];
    end
  end
  assign cout1  = co_flat[0] ^ co_mask[0];
  assign cout2  = co_flat[1] ^ co_mask[1];
  assign cout24 = co_flat[2] ^ co_mask[2];

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] flat(input int s);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < COEFF_DEPTH; i++) r[i*W +: W] = model[s][i];
    return r;
  endfunction

  function automatic logic [BW-1:0] act_bank(input int s);
    return (s == 0) ? cin1 : (s == 1) ? cin2 : cin24;
  endfunction

  task automatic check_banks(input string tag);
    for (int s = 0; s < 3; s++) chk($sformatf("%s_bank%0d", tag, s), act_bank(s), flat(s));
  endtask

  task automatic clear_model();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < COEFF_DEPTH; i++) model[s][i] = '0;
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns 1 ns after the edge that took the word.
  task automatic send_word(input logic [1:0] s, input logic [2:0] idx, input logic [W-1:0] d,
                           input logic last, input bit expect_commit);
    int n;
    cfg_valid = 1'b1; cfg_sel = s; cfg_idx = idx; cfg_data = d; cfg_last = last;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      chk("cfg_ready_timeout", 0, 1);
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (s != 2'd3 && idx < 3'd5) begin
      model[s][idx] = d;
      if (last && expect_commit) begin
        exp_q.push_back({s, flat(s)});
        commits_exp++;
      end
    end
  endtask

  task automatic idle();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic wait_load_done(input string name, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_done && n < 10);
    chk(name, n, exp_lat);
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    @(posedge clk); #1;
    status_clr = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [BW+1:0] exp_rec, act_rec;
    logic [1:0]    act_sel;
    forever begin
      @(negedge clk);
      if (prev_wr) begin
        chk("wr_en_one_cycle", {wr24, wr2, wr1}, 3'b000);
`ifdef IIR_LOADER_READBACK_EN
        chk("load_done_in_check", load_done, 1'b1);
`endif
      end
      if (load_done) ld_seen++;
      prev_wr = 1'b0;
      if (wr1 || wr2 || wr24) begin
        prev_wr = 1'b1;
        chk("wr_en_onehot", $countones({wr24, wr2, wr1}), 1);
        chk("ready_low_in_write", cfg_ready, 1'b0);
        chk("load_done_in_write", load_done, (LAT == 1) ? 1'b1 : 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_en", 1, 0);
        end else begin
          exp_rec = exp_q.pop_front();
          act_sel = wr24 ? 2'd2 : (wr2 ? 2'd1 : 2'd0);
          act_rec = {act_sel, act_bank(int'(act_sel))};
          chk("commit_contents", act_rec, exp_rec);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ld_before, n;
    rst = 1'b1; cfg_valid = 1'b0; cfg_sel = '0; cfg_idx = '0; cfg_data = '0; cfg_last = 1'b0;
    ovf1 = 0; ovf2 = 0; ovf24 = 0; udf1 = 0; udf2 = 0; udf24 = 0; status_clr = 1'b0;
    for (int s = 0; s < 3; s++) co_mask[s] = '0;
    clear_model();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_wr_en", {wr24, wr2, wr1}, 3'b000);
    chk("rst_sticky", {sticky_ovf, sticky_udf, cfg_err, verify_err}, 8'h00);
    check_banks("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Five words to the 2.4 MHz bank, commit on idx 4.
    for (int i = 0; i < 5; i++) send_word(2'd2, 3'(i), 20'h10000 + W'(i), (i == 4), 1'b1);
    idle();
    wait_load_done("commit_latency", LAT);
    chk("bank2_4_values", cin24, 100'h1000410003100021000110000);
    repeat (3) @(negedge clk);
    chk("clean_commit_verify_err", verify_err, 1'b0);
    check_banks("t1");

    // Illegal idx, then illegal sel with last: dropped, flagged, no commit.
    @(posedge clk); #1;
    send_word(2'd0, 3'd5, 20'hABCDE, 1'b0, 1'b0);
    send_word(2'd3, 3'd1, 20'h12345, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("illegal_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("illegal_cfg_err", cfg_err, 1'b1);
    check_banks("t2");
    @(posedge clk); #1;
    pulse_clr();
    @(negedge clk);
    chk("cfg_err_cleared", cfg_err, 1'b0);

    // Readback corruption on the 1 MHz bank, slot 3.
    @(posedge clk); #1;
    co_mask[0] = '0;
    co_mask[0][3*W +: W] = 20'h3FFFF ^ 20'h00001;
    send_word(2'd0, 3'd0, 20'h00011, 1'b0, 1'b1);
    send_word(2'd0, 3'd1, 20'h00022, 1'b0, 1'b1);
    send_word(2'd0, 3'd2, 20'h00033, 1'b0, 1'b1);
    send_word(2'd0, 3'd3, 20'h3FFFF, 1'b0, 1'b1);
    send_word(2'd0, 3'd4, 20'h00055, 1'b1, 1'b1);
    idle();
    wait_load_done("verify_commit_latency", LAT);
    @(negedge clk);
    chk("verify_err_set", verify_err, (LAT == 2) ? 1'b1 : 1'b0);
    @(posedge clk); #1;
    pulse_clr();
    @(negedge clk);
    chk("verify_err_cleared", verify_err, 1'b0);
    co_mask[0] = '0;
    check_banks("t3");

    // Sticky status: set, then a set event colliding with status_clr.
    @(posedge clk); #1;
    ovf1 = 1'b1; udf24 = 1'b1;
    @(posedge clk); #1;
    ovf1 = 1'b0; udf24 = 1'b0;
    @(negedge clk);
    chk("sticky_ovf_set", sticky_ovf, 3'b001);
    chk("sticky_udf_set", sticky_udf, 3'b100);
    @(posedge clk); #1;
    ovf2 = 1'b1; status_clr = 1'b1;
    @(posedge clk); #1;
    ovf2 = 1'b0; status_clr = 1'b0;
    @(negedge clk);
    chk("sticky_ovf_set_wins", sticky_ovf, 3'b010);
    chk("sticky_udf_cleared", sticky_udf, 3'b000);

    // Ten back-to-back words with cfg_valid held, last on words 5 and 10.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_word(2'd1, 3'(i), 20'h20000 + W'(i), (i == 4), 1'b1);
    for (int i = 0; i < 5; i++) send_word(2'd1, 3'(4 - i), 20'h30000 + W'(i), (i == 4), 1'b1);
    idle();
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_drain", (n < 50), 1'b1);
    chk("b2b_bank1_values", cin2, 100'h3000030001300023000330004);
    check_banks("t5");

    // Reset asserted in the WRITE cycle discards the commit.
    @(posedge clk); #1;
    ld_before = ld_seen;
    send_word(2'd1, 3'd0, 20'h0AAAA, 1'b0, 1'b0);
    send_word(2'd1, 3'd1, 20'h0BBBB, 1'b1, 1'b0);
    chk("write_state_strobe", wr2, 1'b1);
    rst = 1'b1;
    idle();
    clear_model();
    #1;
    chk("rst_mid_write_wr_en", {wr24, wr2, wr1}, 3'b000);
    chk("rst_mid_write_load_done", load_done, 1'b0);
    chk("rst_mid_write_ready", cfg_ready, 1'b1);
    check_banks("rst_mid_write");
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", cfg_ready, 1'b1);
    chk("post_rst_sticky", {sticky_ovf, sticky_udf}, 6'b000000);
    chk("post_rst_no_load_done", ld_seen, ld_before);

    repeat (3) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("load_done_count", ld_seen, commits_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
